// File: rtl/synth_pkg.sv
// Shared constants and types for the instrument sample playback path.
// Sample ROMs hold 48001 signed 24-bit entries; envelope unity gain is 256.
package synth_pkg;

  localparam int SAMPLE_LAST_ADDR = 48000;
  localparam int SAMPLE_ADDR_W    = 17;
  localparam int SAMPLE_DATA_W    = 24;
  localparam int ENV_UNITY        = 256;

  typedef logic signed [SAMPLE_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } player_state_e;

endpackage

// File: rtl/sample_player_if.sv
// ROM read bus plus the valid/ready sample stream leaving the player.
// master = player side, slave = ROM and audio sink side.
interface sample_player_if
  import synth_pkg::*;
#(
  parameter int ADDR_W = SAMPLE_ADDR_W,
  parameter int DATA_W = SAMPLE_DATA_W
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output sample_out,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  sample_out,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/env_scale.sv
// Registered envelope gain: o_sample = (i_data * i_env) >>> SHIFT, captured on i_en.
// i_env is unsigned and never exceeds unity, so the kept bits are exact.
module env_scale
  import synth_pkg::*;
#(
  parameter int DATA_W = SAMPLE_DATA_W,
  parameter int ENV_W  = 9,
  parameter int SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic        [ENV_W-1:0]  i_env,
  output logic signed [DATA_W-1:0] o_sample
);

  localparam int PROD_W = DATA_W + ENV_W + 1;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [DATA_W-1:0] r_sample;
  logic                     w_unused_bits;

  // Zero-extend the envelope before the signed multiply so 256 stays positive.
  assign w_prod = i_data * $signed({1'b0, i_env});
  assign w_unused_bits = ^{w_prod[PROD_W-1:SHIFT+DATA_W], w_prod[SHIFT-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
    end else if (i_en) begin
      r_sample <= w_prod[SHIFT +: DATA_W];
    end
  end

  assign o_sample = r_sample;

endmodule

// File: rtl/sample_player.sv
// Sample ROM read controller: phase-accumulator pitch, sustain loop, linear
// release envelope and a valid/ready output stage.
module sample_player
  import synth_pkg::*;
#(
  parameter int ADDR_W    = SAMPLE_ADDR_W,
  parameter int DATA_W    = SAMPLE_DATA_W,
  parameter int LAST_ADDR = SAMPLE_LAST_ADDR,
  parameter int FRAC_W    = 8,
  parameter int STEP_W    = 16,
  parameter int ENV_W     = 9,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              note_on,
  input  logic              note_off,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] loop_start,
  input  logic [STEP_W-1:0] step,
  input  logic [7:0]        decay,
  output logic              busy,
  sample_player_if.master   sp
);

  localparam int PH_W   = ADDR_W + FRAC_W;
  localparam int NX_W   = PH_W + 1;
  localparam int WAIT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT);

  player_state_e     r_state;
  logic [PH_W-1:0]   r_phase;
  logic [ENV_W-1:0]  r_env;
  logic              r_releasing;
  logic [WAIT_W-1:0] r_wait;
  logic              r_valid;

  logic [NX_W-1:0]   w_next;
  logic              w_past_end;
  logic [ENV_W-1:0]  w_decay;
  logic [ENV_W-1:0]  w_env_dec;
  logic              w_capture;
  logic [DATA_W-1:0] w_sample;

  // One extra bit keeps the carry out of the top address bit visible to the
  // end-of-sample compare.
  assign w_next     = NX_W'(r_phase) + NX_W'(step);
  assign w_past_end = w_next[NX_W-1:FRAC_W] > (ADDR_W + 1)'(LAST_ADDR);

  assign w_decay   = ENV_W'(decay);
  assign w_env_dec = !r_releasing        ? r_env :
                     (r_env > w_decay)   ? r_env - w_decay : '0;

  // Must mirror the FETCH branch below, including note_on priority.
  assign w_capture = (r_state == FETCH) && (r_wait == WAIT_LAST) && !note_on;

  // NOTE: every register in this block is assigned with <= so all of them
  // update from the same pre-edge values; mixing in = would order-couple them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_env       <= '0;
      r_releasing <= 1'b0;
      r_wait      <= '0;
      r_valid     <= 1'b0;
    end else if (note_on) begin
      r_state     <= FETCH;
      r_phase     <= '0;
      r_env       <= ENV_W'(ENV_UNITY);
      r_releasing <= 1'b0;
      r_wait      <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (note_off && (r_state != IDLE)) begin
        r_releasing <= 1'b1;
      end
      case (r_state)
        IDLE: begin
        end
        FETCH: begin
          if (r_wait == WAIT_LAST) begin
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        PRESENT: begin
          if (sp.sample_ready) begin
            r_valid <= 1'b0;
            r_env   <= w_env_dec;
            r_wait  <= '0;
            if (w_env_dec == '0) begin
              r_state <= IDLE;
            end else if (w_past_end && !loop_en) begin
              r_state <= IDLE;
            end else begin
              r_state <= FETCH;
              r_phase <= w_past_end ? {loop_start, w_next[FRAC_W-1:0]}
                                    : w_next[PH_W-1:0];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  env_scale #(
    .DATA_W (DATA_W),
    .ENV_W  (ENV_W),
    .SHIFT  (8)
  ) u_env_scale (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_en     (w_capture),
    .i_data   ($signed(sp.rom_data)),
    .i_env    (r_env),
    .o_sample (w_sample)
  );

  assign sp.rom_addr     = r_phase[FRAC_W +: ADDR_W];
  assign sp.sample_out   = w_sample;
  assign sp.sample_valid = r_valid;
  assign busy            = (r_state != IDLE);

endmodule
